// File: rtl/mips_pkg.sv
// ============================================================================
// mips_pkg
// Shared constants for the MIPS pipeline exception path: ExcCodes, CP0
// register numbers, exception-controller FSM encoding and EPC helper.
// Revision: 1.0
// ============================================================================
`default_nettype none

package mips_pkg;

   // Exception codes as stored in Cause.ExcCode
   localparam logic [4:0] EXC_INT  = 5'd0;
   localparam logic [4:0] EXC_ADEL = 5'd4;
   localparam logic [4:0] EXC_ADES = 5'd5;
   localparam logic [4:0] EXC_RI   = 5'd10;
   localparam logic [4:0] EXC_OV   = 5'd12;

   // CP0 register numbers seen by mfc0/mtc0
   localparam logic [4:0] CP0_SR    = 5'd12;
   localparam logic [4:0] CP0_CAUSE = 5'd13;
   localparam logic [4:0] CP0_EPC   = 5'd14;
   localparam logic [4:0] CP0_PRID  = 5'd15;

   // Exception sequencing states
   typedef enum logic [1:0] {
      ST_RUN      = 2'd0,
      ST_FLUSH    = 2'd1,
      ST_REDIRECT = 2'd2
   } exc_state_t;

   // Restart address: a delay-slot instruction resumes at its branch
   function automatic logic [31:0] exc_epc(input logic [31:0] pc, input logic bd);
      logic [31:0] raw;
      raw = bd ? (pc - 32'd4) : pc;
      return {raw[31:2], 2'b00};
   endfunction

endpackage

`default_nettype wire

// File: rtl/cp0_regs.sv
// ============================================================================
// cp0_regs
// Storage for CP0 SR, Cause and EPC plus the combinational mfc0 read mux.
// Exception/eret updates take precedence over mtc0 writes.
// Revision: 1.0
// ============================================================================
`default_nettype none

module cp0_regs
   import mips_pkg::*;
#(
   parameter logic [31:0] PRID = 32'h0000_2017
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [5:0]  hwint,
   input  logic        wr_en,
   input  logic [4:0]  addr,
   input  logic [31:0] wdata,
   input  logic        exc_take,
   input  logic [4:0]  exc_code,
   input  logic        exc_bd,
   input  logic [31:0] exc_pc,
   input  logic        eret_take,
   output logic [5:0]  im,
   output logic        exl,
   output logic        ie,
   output logic [5:0]  ip,
   output logic [31:0] epc,
   output logic [31:0] rdata
);

   logic       cause_bd;
   logic [4:0] cause_code;

   // Interrupt pending bits follow the hardware lines one cycle late
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ip <= '0;
      end else begin
         ip <= hwint;
      end
   end

   // SR/Cause/EPC update: exception entry, eret return, else mtc0 write
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         im         <= '0;
         exl        <= 1'b0;
         ie         <= 1'b0;
         cause_bd   <= 1'b0;
         cause_code <= '0;
         epc        <= '0;
      end else if (exc_take) begin
         exl        <= 1'b1;
         cause_bd   <= exc_bd;
         cause_code <= exc_code;
         epc        <= exc_pc;
      end else if (eret_take) begin
         exl <= 1'b0;
      end else if (wr_en) begin
         if (addr == CP0_SR) begin
            im  <= wdata[15:10];
            exl <= wdata[1];
            ie  <= wdata[0];
         end else if (addr == CP0_EPC) begin
            epc <= {wdata[31:2], 2'b00};
         end
      end
   end

   // mfc0 read mux over the current (pre-edge) register contents
   always_comb begin
      rdata = '0;
      case (addr)
         CP0_SR:    rdata = {16'b0, im, 8'b0, exl, ie};
         CP0_CAUSE: rdata = {cause_bd, 15'b0, ip, 3'b0, cause_code, 2'b0};
         CP0_EPC:   rdata = epc;
         CP0_PRID:  rdata = PRID;
         default:   rdata = '0;
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/exc_ctrl.sv
// ============================================================================
// exc_ctrl
// M-stage exception/interrupt controller: arbitrates interrupts, pipelined
// exceptions and eret, then sequences flush and PC redirect.
// Revision: 1.0
// ============================================================================
`default_nettype none

module exc_ctrl
   import mips_pkg::*;
#(
   parameter logic [31:0] HANDLER_PC = 32'h0000_4180,
   parameter logic [31:0] PRID       = 32'h0000_2017
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        ExceptionM,
   input  logic [4:0]  ExcM,
   input  logic [31:0] PCM,
   input  logic        BDM,
   input  logic        eretM,
   input  logic [5:0]  hwint,
   input  logic        cp0_we,
   input  logic [4:0]  cp0_addr,
   input  logic [31:0] cp0_wdata,
   output logic [31:0] cp0_rdata,
   output logic        flush,
   output logic        redirect,
   output logic [31:0] redirect_pc,
   output logic [31:0] epc
);

   exc_state_t  state;
   logic [5:0]  sr_im;
   logic        sr_exl;
   logic        sr_ie;
   logic [5:0]  cause_ip;
   logic        in_run;
   logic        int_req;
   logic        take_exc;
   logic        take_eret;
   logic        accept;
   logic        wr_en;
   logic [4:0]  code;
   logic [31:0] target;

   assign in_run    = (state == ST_RUN);
   assign int_req   = (|(cause_ip & sr_im)) & sr_ie & ~sr_exl;
   // Interrupt beats a pipelined exception, which beats eret
   assign take_exc  = in_run & (int_req | ExceptionM);
   assign take_eret = in_run & ~int_req & ~ExceptionM & eretM;
   assign accept    = take_exc | take_eret;
   assign code      = int_req ? EXC_INT : ExcM;
   assign target    = take_exc ? HANDLER_PC : epc;
   // mtc0 only lands in RUN on a cycle with no accepted event
   assign wr_en     = in_run & cp0_we & ~accept;

   cp0_regs #(
      .PRID (PRID)
   ) u_cp0_regs (
      .clk       (clk),
      .reset     (reset),
      .hwint     (hwint),
      .wr_en     (wr_en),
      .addr      (cp0_addr),
      .wdata     (cp0_wdata),
      .exc_take  (take_exc),
      .exc_code  (code),
      .exc_bd    (BDM),
      .exc_pc    (exc_epc(PCM, BDM)),
      .eret_take (take_eret),
      .im        (sr_im),
      .exl       (sr_exl),
      .ie        (sr_ie),
      .ip        (cause_ip),
      .epc       (epc),
      .rdata     (cp0_rdata)
   );

   // RUN -> FLUSH -> REDIRECT -> RUN sequencer with registered outputs
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= ST_RUN;
         flush       <= 1'b0;
         redirect    <= 1'b0;
         redirect_pc <= '0;
      end else begin
         case (state)
            ST_RUN: begin
               if (accept) begin
                  state       <= ST_FLUSH;
                  flush       <= 1'b1;
                  redirect_pc <= target;
               end
            end
            ST_FLUSH: begin
               state    <= ST_REDIRECT;
               flush    <= 1'b0;
               redirect <= 1'b1;
            end
            ST_REDIRECT: begin
               state    <= ST_RUN;
               redirect <= 1'b0;
            end
            default: begin
               state    <= ST_RUN;
               flush    <= 1'b0;
               redirect <= 1'b0;
            end
         endcase
      end
   end

endmodule

`default_nettype wire
